// File: rtl/zuc256_lfsr_ctrl.sv
// ---------------------------------------------------------------------------
// zuc256_lfsr_ctrl
// Holds the sixteen 31-bit ZUC-256 LFSR cells and sequences one LFSR clock
// at a time through the external zuc256_modadd block. It presents the tapped
// cells, W>>1 and the init flag, pulses ma_start, waits for ma_ready, and then
// shifts the register so that the modadd result becomes the new s15.
// It also drives the bit-reorganisation words X0..X3.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   load, load_data[495:0]  load all cells (cell i = load_data[31*i +: 31])
//   step, init_mode, w_in   request one LFSR clock; mode and W sampled with step
//   ma_start                one-cycle start pulse to modadd
//   ma_s15..ma_s0           tapped cells (stable while busy)
//   ma_w_shifted            held w_in[31:1]
//   ma_came_from_init       held init_mode
//   ma_out, ma_ready        modadd result and completion pulse
//   busy                    high while a step is in flight (ISSUE/WAIT)
//   step_done               one-cycle pulse the cycle after the shift
//   err[1:0], err_clr       sticky errors: [0] ready timeout, [1] load/step while busy
//   x0..x3                  bit reorganisation of the current cells
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | accepts load / step
// ISSUE | ma_start high for this one cycle, timeout timer armed
// WAIT  | waiting for ma_ready; shift on ready, abort on timer expiry
// ---------------------------------------------------------------------------
module zuc256_lfsr_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic [495:0]  load_data,
    input  logic          step,
    input  logic          init_mode,
    input  logic [31:0]   w_in,
    output logic          ma_start,
    output logic [30:0]   ma_s15,
    output logic [30:0]   ma_s13,
    output logic [30:0]   ma_s10,
    output logic [30:0]   ma_s4,
    output logic [30:0]   ma_s0,
    output logic [30:0]   ma_w_shifted,
    output logic          ma_came_from_init,
    input  logic [30:0]   ma_out,
    input  logic          ma_ready,
    output logic          busy,
    output logic          step_done,
    output logic [1:0]    err,
    input  logic          err_clr,
    output logic [31:0]   x0,
    output logic [31:0]   x1,
    output logic [31:0]   x2,
    output logic [31:0]   x3
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t        state;
    logic [30:0]   cells [16];
    logic [30:0]   w_hold;
    logic          init_hold;
    logic [TW-1:0] timer;

    logic          timeout_hit;
    logic          busy_viol;
    logic          unused_w_lsb;

    // W is only ever used as W>>1, so its LSB is dropped here.
    assign unused_w_lsb = w_in[0];

    // Timer counts down from TIMEOUT_CYCLES-1; WAIT lasts at most TIMEOUT_CYCLES
    // cycles and a ready arriving in the last of them still wins.
    assign timeout_hit = (state == ST_WAIT) && !ma_ready && (timer == '0);
    assign busy_viol   = (state != ST_IDLE) && (load || step);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            for (int i = 0; i < 16; i++) cells[i] <= '0;
            w_hold    <= '0;
            init_hold <= 1'b0;
            timer     <= '0;
            ma_start  <= 1'b0;
            busy      <= 1'b0;
            step_done <= 1'b0;
            err       <= '0;
        end else begin
            ma_start  <= 1'b0;
            step_done <= 1'b0;
            // A new error in the same cycle as err_clr keeps its bit set.
            err[0] <= (err[0] & ~err_clr) | timeout_hit;
            err[1] <= (err[1] & ~err_clr) | busy_viol;

            case (state)
                ST_IDLE: begin
                    if (load) begin
                        for (int i = 0; i < 16; i++) cells[i] <= load_data[31*i +: 31];
                    end else if (step) begin
                        w_hold    <= w_in[31:1];
                        init_hold <= init_mode;
                        ma_start  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= TW'(TIMEOUT_CYCLES - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ma_ready) begin
                        for (int i = 0; i < 15; i++) cells[i] <= cells[i+1];
                        cells[15] <= ma_out;
                        step_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (timer == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ma_s15            = cells[15];
    assign ma_s13            = cells[13];
    assign ma_s10            = cells[10];
    assign ma_s4             = cells[4];
    assign ma_s0             = cells[0];
    assign ma_w_shifted      = w_hold;
    assign ma_came_from_init = init_hold;

    assign x0 = {cells[15][30:15], cells[14][15:0]};
    assign x1 = {cells[11][15:0],  cells[9][30:15]};
    assign x2 = {cells[7][15:0],   cells[5][30:15]};
    assign x3 = {cells[2][15:0],   cells[0][30:15]};

endmodule

// File: tb/tb_zuc256_lfsr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_zuc256_lfsr_ctrl
// Directed bench for zuc256_lfsr_ctrl. A behavioural modadd peer answers
// ma_start after 4 (work) / 5 (init) cycles, or never, or after a chosen
// latency. Expected new s15 values are queued when a step is driven and
// popped when step_done appears; a cell model tracks the whole register.
// ---------------------------------------------------------------------------
module tb_zuc256_lfsr_ctrl;

    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic [495:0]  load_data = '0;
    logic          step = 1'b0;
    logic          init_mode = 1'b0;
    logic [31:0]   w_in = '0;
    logic          ma_start;
    logic [30:0]   ma_s15, ma_s13, ma_s10, ma_s4, ma_s0;
    logic [30:0]   ma_w_shifted;
    logic          ma_came_from_init;
    logic [30:0]   ma_out;
    logic          ma_ready;
    logic          busy;
    logic          step_done;
    logic [1:0]    err;
    logic          err_clr = 1'b0;
    logic [31:0]   x0, x1, x2, x3;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [30:0]   exp_q [$];
    logic [30:0]   m [16];

    int            stub_never = 0;
    int            lat_override = 0;
    int            cnt;

    zuc256_lfsr_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .load_data(load_data),
        .step(step), .init_mode(init_mode), .w_in(w_in),
        .ma_start(ma_start), .ma_s15(ma_s15), .ma_s13(ma_s13), .ma_s10(ma_s10),
        .ma_s4(ma_s4), .ma_s0(ma_s0), .ma_w_shifted(ma_w_shifted),
        .ma_came_from_init(ma_came_from_init), .ma_out(ma_out), .ma_ready(ma_ready),
        .busy(busy), .step_done(step_done), .err(err), .err_clr(err_clr),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3)
    );

    always #5 clk = ~clk;

    // ZUC-256 LFSR feedback: sum of 2^k-weighted taps (+ W>>1 in init) mod 2^31-1,
    // with zero mapped to 2^31-1.
    function automatic logic [30:0] modadd(input logic [30:0] a15, a13, a10, a4, a0, u,
                                           input logic init);
        logic [63:0] s;
        s = (64'(a15) << 15) + (64'(a13) << 17) + (64'(a10) << 21) + (64'(a4) << 20)
          + 64'(a0) * 64'd257 + (init ? 64'(u) : 64'd0);
        s = s % 64'h7FFF_FFFF;
        if (s == 64'd0) s = 64'h7FFF_FFFF;
        return s[30:0];
    endfunction

    // Modadd peer sharing reset_n.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= 0;
            ma_ready <= 1'b0;
            ma_out   <= '0;
        end else begin
            ma_ready <= 1'b0;
            if (ma_start && stub_never == 0) begin
                ma_out <= modadd(ma_s15, ma_s13, ma_s10, ma_s4, ma_s0, ma_w_shifted,
                                 ma_came_from_init);
                cnt <= (lat_override != 0 ? lat_override : (ma_came_from_init ? 5 : 4)) - 1;
            end else if (cnt == 1) begin
                ma_ready <= 1'b1;
                cnt      <= 0;
            end else if (cnt > 1) begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cells(input string tag);
        check({tag, " s15"}, 64'(ma_s15), 64'(m[15]));
        check({tag, " s13"}, 64'(ma_s13), 64'(m[13]));
        check({tag, " s10"}, 64'(ma_s10), 64'(m[10]));
        check({tag, " s4"},  64'(ma_s4),  64'(m[4]));
        check({tag, " s0"},  64'(ma_s0),  64'(m[0]));
        check({tag, " x0"}, 64'(x0), 64'({m[15][30:15], m[14][15:0]}));
        check({tag, " x1"}, 64'(x1), 64'({m[11][15:0], m[9][30:15]}));
        check({tag, " x2"}, 64'(x2), 64'({m[7][15:0], m[5][30:15]}));
        check({tag, " x3"}, 64'(x3), 64'({m[2][15:0], m[0][30:15]}));
    endtask

    task automatic do_load();
        for (int i = 0; i < 16; i++) load_data[31*i +: 31] = m[i];
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // poke: 0 none, 1 load during ISSUE, 2 step + err_clr during ISSUE
    task automatic do_step(input string tag, input logic init, input logic [31:0] w,
                           input logic [30:0] exp_s15, input bit use_exp, input int poke);
        logic [30:0] e;
        logic [30:0] got_s15;
        bit          got;
        e = use_exp ? exp_s15 : modadd(m[15], m[13], m[10], m[4], m[0], w[31:1], init);
        exp_q.push_back(e);
        step = 1'b1; init_mode = init; w_in = w;
        tick();
        step = 1'b0; init_mode = ~init; w_in = $urandom;
        @(negedge clk);
        check({tag, " ma_start"}, 64'(ma_start), 64'd1);
        check({tag, " busy"}, 64'(busy), 64'd1);
        if (poke == 1) begin
            load = 1'b1; load_data = ~load_data;
            @(negedge clk);
            load = 1'b0;
        end else if (poke == 2) begin
            step = 1'b1; err_clr = 1'b1;
            @(negedge clk);
            step = 1'b0; err_clr = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (ma_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " ready seen"}, 64'(got), 64'd1);
        check({tag, " came_from_init"}, 64'(ma_came_from_init), 64'(init));
        check({tag, " w_shifted"}, 64'(ma_w_shifted), 64'(w[31:1]));
        @(negedge clk);
        check({tag, " step_done"}, 64'(step_done), 64'd1);
        got_s15 = exp_q.pop_front();
        for (int i = 0; i < 15; i++) m[i] = m[i+1];
        m[15] = got_s15;
        check_cells(tag);
        @(negedge clk);
        check({tag, " step_done once"}, 64'(step_done), 64'd0);
        check({tag, " idle"}, 64'(busy), 64'd0);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        // Reset state
        #22;
        check("rst ma_start", 64'(ma_start), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst step_done", 64'(step_done), 64'd0);
        check("rst err", 64'(err), 64'd0);
        check("rst x0", 64'(x0), 64'd0);
        check("rst s15", 64'(ma_s15), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Load s_i = i+1 and check reorganisation
        for (int i = 0; i < 16; i++) m[i] = 31'(i + 1);
        do_load();
        check("load x0", 64'(x0), 64'h0000_000F);
        check("load x1", 64'(x1), 64'h000C_0000);
        check("load x2", 64'(x2), 64'h0008_0000);
        check("load x3", 64'(x3), 64'h0003_0000);
        check_cells("load");

        // Work-mode step
        do_step("t1", 1'b0, 32'h0, 31'h1D4_0101, 1'b1, 0);
        check("t1 err", 64'(err), 64'd0);

        // Init-mode step with W = 2
        for (int i = 0; i < 16; i++) m[i] = 31'(i + 1);
        do_load();
        do_step("t2", 1'b1, 32'h0000_0002, 31'h1D4_0102, 1'b1, 0);

        // All-zero cells map to 2^31-1 in both modes
        for (int i = 0; i < 16; i++) m[i] = '0;
        do_load();
        do_step("t3 init", 1'b1, 32'h0000_0001, 31'h7FFF_FFFF, 1'b1, 0);
        for (int i = 0; i < 16; i++) m[i] = '0;
        do_load();
        do_step("t3 work", 1'b0, 32'h0, 31'h7FFF_FFFF, 1'b1, 0);

        // Random cells, several steps against the model
        for (int i = 0; i < 16; i++) m[i] = 31'($urandom);
        do_load();
        check_cells("rand load");
        for (int n = 0; n < 4; n++) do_step("rand", 1'($urandom), $urandom, '0, 1'b0, 0);

        // load and step together in IDLE: load wins, no error, no step
        for (int i = 0; i < 16; i++) m[i] = 31'($urandom);
        step = 1'b1;
        do_load();
        step = 1'b0;
        @(negedge clk);
        check("load+step busy", 64'(busy), 64'd0);
        check("load+step err", 64'(err), 64'd0);
        check_cells("load+step");
        tick();

        // Ready in the last WAIT cycle wins over timeout
        lat_override = TO;
        do_step("late ready", 1'b0, $urandom, '0, 1'b0, 0);
        check("late ready err", 64'(err), 64'd0);
        lat_override = 0;

        // Timeout with a silent modadd
        stub_never = 1;
        step = 1'b1;
        tick();
        step = 1'b0;
        bc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) bc++;
            else break;
        end
        check("timeout busy window", 64'(bc >= TO && bc <= TO + 1), 64'd1);
        check("timeout err", 64'(err), 64'd1);
        check("timeout busy low", 64'(busy), 64'd0);
        check("timeout no step_done", 64'(step_done), 64'd0);
        check_cells("timeout");
        stub_never = 0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_clr", 64'(err), 64'd0);
        tick();

        // load while busy is ignored and flagged
        do_step("busy load", 1'b0, $urandom, '0, 1'b0, 1);
        check("busy load err", 64'(err), 64'd2);

        // step while busy with err_clr: the new error keeps err[1]
        do_step("busy step", 1'b1, $urandom, '0, 1'b0, 2);
        check("err wins", 64'(err), 64'd2);

        // Asynchronous reset in WAIT
        step = 1'b1; init_mode = 1'b1; w_in = 32'hFFFF_FFFE;
        tick();
        step = 1'b0;
        tick();
        tick();
        check("pre-rst busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst ma_start", 64'(ma_start), 64'd0);
        check("arst busy", 64'(busy), 64'd0);
        check("arst step_done", 64'(step_done), 64'd0);
        check("arst err", 64'(err), 64'd0);
        check("arst w_shifted", 64'(ma_w_shifted), 64'd0);
        check("arst init", 64'(ma_came_from_init), 64'd0);
        for (int i = 0; i < 16; i++) m[i] = '0;
        check_cells("arst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) @(negedge clk);
        check("post-rst busy", 64'(busy), 64'd0);
        check_cells("post-rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
